// File: rtl/sd_access_arbiter_pkg.sv
// rtl/sd_access_arbiter_pkg.sv - shared states, client indices and defaults for the SD access arbiter
package sd_access_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_BUSY  = 2'b11,
      ST_DONE  = 2'b10
   } arb_state_t;

   localparam int CLIENT_ASSET    = 0;
   localparam int CLIENT_SCORE_RD = 1;
   localparam int CLIENT_SCORE_WR = 2;

   localparam int DEFAULT_TIMEOUT = 1024;

   function automatic int ptr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/sd_access_arbiter_rr_pick.sv
// rtl/sd_access_arbiter_rr_pick.sv - combinational round-robin selector, first request at or after the pointer
module sd_access_arbiter_rr_pick
   import sd_access_arbiter_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);
   int w_j;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_j      = 0;
      for (int k = 0; k < N; k++) begin
         w_j = (int'(i_ptr) + k) % N;
         if (!o_valid && i_req[w_j[IDX_W-1:0]]) begin
            o_valid                 = 1'b1;
            o_onehot[w_j[IDX_W-1:0]] = 1'b1;
            o_idx                   = w_j[IDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/sd_access_arbiter.sv
// rtl/sd_access_arbiter.sv - round-robin owner of the SD controller request/busy handshake
module sd_access_arbiter
   import sd_access_arbiter_pkg::*;
#(
   parameter int N_CLIENTS = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 16,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [N_CLIENTS-1:0]          REQ,
   input  logic [N_CLIENTS-1:0]          REQ_WRITE,
   input  logic [N_CLIENTS*ADDR_W-1:0]   REQ_ADDR,
   input  logic [N_CLIENTS*DATA_W-1:0]   REQ_WDATA,
   output logic [N_CLIENTS-1:0]          GRANT,
   output logic [N_CLIENTS-1:0]          DONE,
   output logic [N_CLIENTS-1:0]          ERROR,
   output logic [DATA_W-1:0]             RDATA,
   input  logic                          SD_HAS_INITIALIZED,
   input  logic                          SD_IS_WRITING,
   input  logic                          SD_IS_READING,
   input  logic [DATA_W-1:0]             SD_READ_DATA,
   output logic                          SD_TO_WRITE,
   output logic                          SD_TO_READ,
   output logic [ADDR_W-1:0]             SD_ADDRESS,
   output logic [DATA_W-1:0]             SD_WRITE_DATA
);
   localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t           r_state;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_owner;
   logic                 r_write;
   logic [CNT_W-1:0]     r_tcnt;

   logic [N_CLIENTS-1:0] w_onehot;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_valid;
   logic                 w_busy;
   logic                 w_accept;
   logic [IDX_W-1:0]     w_ptr_next;

   sd_access_arbiter_rr_pick #(
      .N     (N_CLIENTS),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req    (REQ),
      .i_ptr    (r_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_valid  (w_valid)
   );

   // Only the busy flag matching the latched op advances the handshake.
   assign w_busy     = r_write ? SD_IS_WRITING : SD_IS_READING;
   assign w_accept   = w_valid && SD_HAS_INITIALIZED && !SD_IS_WRITING && !SD_IS_READING;
   assign w_ptr_next = IDX_W'(ptr_next(int'(r_owner), N_CLIENTS));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= ST_IDLE;
         r_ptr         <= IDX_W'(CLIENT_ASSET);
         r_owner       <= '0;
         r_write       <= 1'b0;
         r_tcnt        <= '0;
         GRANT         <= '0;
         DONE          <= '0;
         ERROR         <= '0;
         RDATA         <= '0;
         SD_TO_WRITE   <= 1'b0;
         SD_TO_READ    <= 1'b0;
         SD_ADDRESS    <= '0;
         SD_WRITE_DATA <= '0;
      end else begin
         DONE  <= '0;
         ERROR <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner       <= w_idx;
                  r_write       <= REQ_WRITE[w_idx];
                  SD_ADDRESS    <= REQ_ADDR[w_idx*ADDR_W +: ADDR_W];
                  SD_WRITE_DATA <= REQ_WDATA[w_idx*DATA_W +: DATA_W];
                  GRANT         <= w_onehot;
                  SD_TO_WRITE   <= REQ_WRITE[w_idx];
                  SD_TO_READ    <= !REQ_WRITE[w_idx];
                  r_tcnt        <= '0;
                  r_state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_busy) begin
                  SD_TO_WRITE <= 1'b0;
                  SD_TO_READ  <= 1'b0;
                  r_state     <= ST_BUSY;
               end else if (r_tcnt == CNT_W'(TIMEOUT - 1)) begin
                  ERROR       <= GRANT;
                  GRANT       <= '0;
                  SD_TO_WRITE <= 1'b0;
                  SD_TO_READ  <= 1'b0;
                  r_ptr       <= w_ptr_next;
                  r_state     <= ST_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            ST_BUSY: begin
               if (!w_busy) begin
                  if (!r_write) begin
                     RDATA <= SD_READ_DATA;
                  end
                  DONE    <= GRANT;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               GRANT   <= '0;
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/sd_access_arbiter.md
Name: sd_access_arbiter

Overview:
- Shares the single SD card controller between several game-side clients: score writer, score reader and asset loader.
- Each client presents a level request with operation, address and write data.
- The arbiter picks one client round-robin, sequences the SD controller's request/busy handshake, and returns a one-cycle DONE (plus read data) or ERROR to that client.
- Sits between the score/asset FSMs and the SD controller; it is the only driver of the SD controller's request inputs.

Parameters:
- N_CLIENTS, 3, number of requesters (index 0 = asset loader, 1 = score reader, 2 = score writer).
- ADDR_W, 32, SD sector address width.
- DATA_W, 16, read/write data width.
- TIMEOUT, 1024, ISSUE-state cycles allowed before the SD busy flag must rise.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  N_CLIENTS  per-client level request
- REQ_WRITE  in  N_CLIENTS  per-client op: 1 = write, 0 = read
- REQ_ADDR  in  N_CLIENTS*ADDR_W  packed addresses; client i at bits [i*ADDR_W +: ADDR_W]
- REQ_WDATA  in  N_CLIENTS*DATA_W  packed write data; same packing as REQ_ADDR
- GRANT  out  N_CLIENTS  one-hot owner of the current transaction
- DONE  out  N_CLIENTS  one-cycle completion pulse to the owner
- ERROR  out  N_CLIENTS  one-cycle timeout pulse to the owner
- RDATA  out  DATA_W  read data, valid from the DONE cycle until the next read completes
- SD_HAS_INITIALIZED  in  1  SD controller ready
- SD_IS_WRITING  in  1  SD write busy
- SD_IS_READING  in  1  SD read busy
- SD_READ_DATA  in  DATA_W  SD read result, stable when SD_IS_READING falls
- SD_TO_WRITE  out  1  write request to SD controller
- SD_TO_READ  out  1  read request to SD controller
- SD_ADDRESS  out  ADDR_W  latched address of the current transaction
- SD_WRITE_DATA  out  DATA_W  latched write data of the current transaction

Behaviour:
- All outputs are registered.
- Reset: RESET is synchronous, active-high, clock CLK.
  - State goes to IDLE.
  - GRANT, DONE, ERROR, SD_TO_WRITE, SD_TO_READ, RDATA, SD_ADDRESS and SD_WRITE_DATA all go to 0.
  - Round-robin pointer goes to 0, so client 0 has highest priority.
  - Reset mid-transaction abandons it silently: no DONE or ERROR, and strobes are low on the cycle after the reset edge.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Accept when there is any REQ and SD_HAS_INITIALIZED=1 and SD_IS_WRITING=0 and SD_IS_READING=0.
  - Winner is the first REQ bit at or after the pointer, wrapping modulo N_CLIENTS.
  - On accept, latch winner index, op, address and write data; set GRANT[winner]; go to ISSUE.
  - Next cycle, SD_TO_WRITE or SD_TO_READ (per op) is 1. Accept-to-strobe latency is one cycle.
- ISSUE:
  - Hold the strobe high until the matching busy flag is 1 (SD_IS_WRITING for writes, SD_IS_READING for reads), then go to BUSY and drop the strobe.
  - The non-matching busy flag is ignored.
  - Timeout counter starts at 0 on entry and increments each ISSUE cycle. On reaching TIMEOUT-1 without the matching busy:
    - pulse ERROR[owner] for one cycle;
    - drop the strobe and GRANT;
    - advance the pointer to owner+1;
    - go to IDLE.
- BUSY:
  - Wait for the matching busy flag to return to 0.
  - On that cycle, capture SD_READ_DATA into RDATA (reads only; RDATA is unchanged by writes); go to DONE.
- DONE:
  - DONE[owner]=1 for exactly one cycle; GRANT stays asserted through this cycle.
  - Pointer becomes owner+1 (wrap); go to IDLE. GRANT clears on the following cycle.
- Client rules:
  - REQ, REQ_WRITE, REQ_ADDR and REQ_WDATA are sampled only at acceptance; later changes do not affect the transaction.
  - A client must drop REQ on DONE/ERROR. If REQ is still high in IDLE it is a new request and competes normally.
  - REQ deasserted while granted does not cancel the transaction.
- Boundaries:
  - REQ while SD not initialised: stays in IDLE indefinitely, no timeout.
  - Simultaneous requests are resolved by the pointer only.
  - A single persistent requester is re-granted back-to-back, minimum 4 cycles per transaction plus SD busy time.
  - GRANT is never more than one-hot. SD_TO_WRITE and SD_TO_READ are never both 1.

Decomposition:
- Shared package/header: state encodings (2-bit: IDLE=00, ISSUE=01, BUSY=11, DONE=10), client index constants (CLIENT_ASSET=0, CLIENT_SCORE_RD=1, CLIENT_SCORE_WR=2) and default TIMEOUT.
- One natural sub-module, rr_pick: combinational round-robin selector taking REQ and the pointer and producing a one-hot winner plus index.
- The FSM, latches and timeout counter stay in the top module.

Test Plan:
- Single write: client 2 REQ=1, REQ_WRITE=1, addr=0x0000_0100, wdata=0x1234; SD model raises IS_WRITING 3 cycles after the strobe and holds it 10 cycles.
  - Expect SD_TO_WRITE high 1 cycle after accept until busy rises.
  - Expect SD_ADDRESS=0x100 and SD_WRITE_DATA=0x1234.
  - Expect DONE[2] for one cycle after busy falls, and GRANT=3'b100 throughout.
- Read: client 1 reads addr 0x200; model returns 0xBEEF when IS_READING falls.
  - Expect RDATA=0xBEEF in the DONE[1] cycle and SD_TO_WRITE never asserted.
- Contention: all three REQ high from reset, each re-raised immediately after its own DONE.
  - Expect grant order 0,1,2,0,1,2.
  - Expect GRANT one-hot and no overlapping transactions.
- Not initialised: REQ[0]=1 with SD_HAS_INITIALIZED=0 for 5000 cycles.
  - Expect no strobe and no ERROR; transaction starts 1 cycle after init rises.
- Timeout: the SD model never asserts busy.
  - Expect ERROR[0] after TIMEOUT ISSUE cycles and strobe low the next cycle.
  - Expect the next contending client (1) granted afterwards.
- Reset mid-op: assert RESET during BUSY of a client 2 write.
  - Expect all outputs 0 the next cycle with no DONE or ERROR.
  - After release with REQ[1] and REQ[2] high, expect client 1 granted first (pointer reset to 0).
